// File: rtl/bht_update_ctrl.sv
// bht_update_ctrl: queues resolved-branch updates into the BHT and sweeps the table clear at init or on request.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_cache_ready(_data) pipeline advance;
// i_ex_* resolved branch from EX; i_flush squash; i_inv_req table invalidate; i_upd_ready predictor ready;
// o_upd_* predictor write port; o_busy sweep active; o_q_full FIFO full; o_drop_cnt dropped updates.
module bht_update_ctrl #(
  parameter int ADDR_WIDTH    = 32,
  parameter int HISTORY_DEPTH = 512,
  parameter int QUEUE_DEPTH   = 4,
  localparam int H_ADDR_WIDTH = $clog2(HISTORY_DEPTH),
  localparam int TAG_WIDTH    = ADDR_WIDTH - H_ADDR_WIDTH - 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_cache_ready,
  input  logic                    i_cache_ready_data,
  input  logic                    i_ex_branch,
  input  logic                    i_ex_taken,
  input  logic [ADDR_WIDTH-1:0]   i_ex_pc,
  input  logic [ADDR_WIDTH-1:0]   i_ex_target,
  input  logic                    i_flush,
  input  logic                    i_inv_req,
  input  logic                    i_upd_ready,
  output logic                    o_upd_valid,
  output logic                    o_upd_clear,
  output logic [H_ADDR_WIDTH-1:0] o_upd_index,
  output logic [TAG_WIDTH-1:0]    o_upd_tag,
  output logic [ADDR_WIDTH-1:0]   o_upd_target,
  output logic                    o_upd_taken,
  output logic                    o_busy,
  output logic                    o_q_full,
  output logic [31:0]             o_drop_cnt
);
  localparam int Q_AW = $clog2(QUEUE_DEPTH);
  localparam int E_W  = H_ADDR_WIDTH + TAG_WIDTH + ADDR_WIDTH + 1;
  localparam logic [Q_AW:0] Q_FULL_CNT = QUEUE_DEPTH[Q_AW:0];

  typedef enum logic [1:0] {S_RST, S_INIT, S_RUN, S_INV} state_t;

  state_t                  r_state, w_next;
  logic [H_ADDR_WIDTH-1:0] r_cnt;
  logic [E_W-1:0]          r_mem [QUEUE_DEPTH];
  logic [Q_AW-1:0]         r_wptr, r_rptr;
  logic [Q_AW:0]           r_count;
  logic [31:0]             r_drop;
  logic                    w_run, w_sweep, w_fire, w_pop, w_push_req, w_push, w_drop, w_full, w_nempty;
  logic [E_W-1:0]          w_head, w_entry;
  logic                    w_unused;

  assign w_unused   = &{1'b0, i_ex_pc[1:0]};
  assign w_run      = r_state == S_RUN;
  assign w_sweep    = r_state == S_INIT || r_state == S_INV;
  assign w_nempty   = r_count != '0;
  assign w_full     = r_count == Q_FULL_CNT;
  assign w_fire     = o_upd_valid & i_upd_ready;
  assign w_pop      = w_run & w_fire;
  // an invalidate in the same cycle discards the push without counting it as a drop
  assign w_push_req = i_cache_ready & i_cache_ready_data & i_ex_branch & ~i_flush & w_run & ~i_inv_req;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_entry    = {i_ex_pc[H_ADDR_WIDTH+1:2], i_ex_pc[ADDR_WIDTH-1:H_ADDR_WIDTH+2], i_ex_target, i_ex_taken};
  assign w_head     = (w_run && w_nempty) ? r_mem[r_rptr] : '0;

  assign o_upd_valid  = w_sweep | (w_run & w_nempty);
  assign o_upd_clear  = w_sweep;
  assign o_upd_index  = w_sweep ? r_cnt : w_head[E_W-1 -: H_ADDR_WIDTH];
  assign o_upd_tag    = w_head[ADDR_WIDTH+1 +: TAG_WIDTH];
  assign o_upd_target = w_head[1 +: ADDR_WIDTH];
  assign o_upd_taken  = w_head[0];
  assign o_busy       = ~w_run;
  assign o_q_full     = w_full;
  assign o_drop_cnt   = r_drop;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_RST;
    else          r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:         w_next = S_INIT;
      S_INIT, S_INV: w_next = (!i_inv_req && w_fire && &r_cnt) ? S_RUN : r_state;
      S_RUN:         w_next = i_inv_req ? S_INV : S_RUN;
      default:       w_next = S_RST;
    endcase
  end

  // sweep counter wraps to 0 naturally after the last index
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)                            r_cnt <= '0;
    else if (r_state == S_RST || i_inv_req)  r_cnt <= '0;
    else if (w_sweep && w_fire)              r_cnt <= r_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_run && i_inv_req) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{Q_AW{1'b0}}, w_push} - {{Q_AW{1'b0}}, w_pop};
    end

  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wptr] <= w_entry;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)                 r_drop <= '0;
    else if (w_drop && ~&r_drop)  r_drop <= r_drop + 1'b1;
endmodule

// File: tb/tb_bht_update_ctrl.sv
// tb_bht_update_ctrl: scoreboard bench for bht_update_ctrl at default parameters.
module tb_bht_update_ctrl;
  logic        clk = 0, rst_n = 1;
  logic        cache_ready = 0, cache_ready_data = 0, ex_branch = 0, ex_taken = 0, flush = 0, inv_req = 0, upd_ready = 0;
  logic [31:0] ex_pc = 0, ex_target = 0;
  logic        upd_valid, upd_clear, upd_taken, busy, q_full;
  logic [8:0]  upd_index;
  logic [20:0] upd_tag;
  logic [31:0] upd_target, drop_cnt;
  int          n_chk = 0, n_err = 0;

  typedef struct {
    logic [8:0]  idx;
    logic [20:0] tag;
    logic [31:0] tgt;
    logic        tk;
  } ent_t;
  ent_t sb[$];

  bht_update_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cache_ready(cache_ready), .i_cache_ready_data(cache_ready_data),
    .i_ex_branch(ex_branch), .i_ex_taken(ex_taken), .i_ex_pc(ex_pc), .i_ex_target(ex_target),
    .i_flush(flush), .i_inv_req(inv_req), .i_upd_ready(upd_ready),
    .o_upd_valid(upd_valid), .o_upd_clear(upd_clear), .o_upd_index(upd_index), .o_upd_tag(upd_tag),
    .o_upd_target(upd_target), .o_upd_taken(upd_taken), .o_busy(busy), .o_q_full(q_full), .o_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic ent_t model(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    ent_t e;
    e.idx = 9'((pc / 4) % 512);
    e.tag = 21'(pc / 2048);
    e.tgt = tgt;
    e.tk  = tk;
    return e;
  endfunction

  task automatic drive_br(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    ex_branch = 1; ex_pc = pc; ex_target = tgt; ex_taken = tk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_check();
    for (int i = 0; i < 512; i++) begin
      chk("sweep_idx", 64'(upd_index), 64'(i));
      chk("sweep_vcb", {61'b0, upd_valid, upd_clear, busy}, 64'b111);
      step();
    end
    chk("run_busy", 64'(busy), 64'd0);
    chk("run_valid", 64'(upd_valid), 64'd0);
  endtask

  // consumer side: a write accepted in RUN must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && upd_valid && !upd_clear && upd_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        ent_t e;
        e = sb.pop_front();
        chk("upd_index", 64'(upd_index), 64'(e.idx));
        chk("upd_tag", 64'(upd_tag), 64'(e.tag));
        chk("upd_target", 64'(upd_target), 64'(e.tgt));
        chk("upd_taken", 64'(upd_taken), 64'(e.tk));
      end
    end
  end

  initial begin
    ent_t first;
    #2 rst_n = 0;
    #1;
    chk("rst_valid", 64'(upd_valid), 64'd0);
    chk("rst_clear", 64'(upd_clear), 64'd0);
    chk("rst_index", 64'(upd_index), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_qfull", 64'(q_full), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    repeat (3) step();
    rst_n = 1; upd_ready = 1; cache_ready = 1; cache_ready_data = 1;
    step();
    sweep_check();

    drive_br(32'h0000_1008, 32'h0000_2000, 1'b1);
    sb.push_back(model(ex_pc, ex_target, ex_taken));
    step();
    ex_branch = 0;
    chk("b1_valid", 64'(upd_valid), 64'd1);
    chk("b1_clear", 64'(upd_clear), 64'd0);
    chk("b1_index", 64'(upd_index), 64'd2);
    chk("b1_tag", 64'(upd_tag), 64'd2);
    chk("b1_target", 64'(upd_target), 64'h2000);
    chk("b1_taken", 64'(upd_taken), 64'd1);
    step();
    chk("b1_drained", 64'(upd_valid), 64'd0);

    upd_ready = 0;
    for (int k = 0; k < 5; k++) begin
      drive_br(32'h0040_0000 + 32'(k) * 32'h44, 32'h0080_0000 + 32'(k) * 32'h10, 1'(k));
      if (k < 4) sb.push_back(model(ex_pc, ex_target, ex_taken));
      step();
      chk("fill_qfull", 64'(q_full), 64'(k >= 3));
    end
    ex_branch = 0;
    first = sb[0];
    chk("fill_drop", 64'(drop_cnt), 64'd1);
    repeat (2) step();
    chk("hold_index", 64'(upd_index), 64'(first.idx));
    chk("hold_target", 64'(upd_target), 64'(first.tgt));
    upd_ready = 1;
    step();
    chk("pop_qfull", 64'(q_full), 64'd0);
    for (int t = 0; t < 20 && sb.size() != 0; t++) step();
    chk("drain_sb", 64'(sb.size()), 64'd0);
    step();
    chk("drain_valid", 64'(upd_valid), 64'd0);

    drive_br(32'h0000_3000, 32'h0000_4000, 1'b1);
    flush = 1;
    step();
    chk("flush_valid", 64'(upd_valid), 64'd0);
    flush = 0; cache_ready = 0;
    step();
    chk("cr_valid", 64'(upd_valid), 64'd0);
    cache_ready = 1; cache_ready_data = 0;
    step();
    chk("crd_valid", 64'(upd_valid), 64'd0);
    chk("nopush_drop", 64'(drop_cnt), 64'd1);
    cache_ready_data = 1; ex_branch = 0;

    upd_ready = 0;
    drive_br(32'h0000_5000, 32'h0000_6000, 1'b0);
    repeat (2) step();
    chk("inv_pre_valid", 64'(upd_valid), 64'd1);
    inv_req = 1;
    step();
    inv_req = 0; ex_branch = 0;
    chk("inv_busy", 64'(busy), 64'd1);
    chk("inv_qfull", 64'(q_full), 64'd0);
    chk("inv_drop", 64'(drop_cnt), 64'd1);
    upd_ready = 1;
    sweep_check();

    inv_req = 1;
    step();
    inv_req = 0;
    repeat (50) step();
    chk("mid_idx50", 64'(upd_index), 64'd50);
    inv_req = 1;
    step();
    inv_req = 0;
    chk("reinv_idx", 64'(upd_index), 64'd0);
    chk("reinv_busy", 64'(busy), 64'd1);
    repeat (200) step();
    chk("mid_idx200", 64'(upd_index), 64'd200);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 64'(upd_valid), 64'd0);
    chk("arst_clear", 64'(upd_clear), 64'd0);
    chk("arst_index", 64'(upd_index), 64'd0);
    chk("arst_busy", 64'(busy), 64'd1);
    chk("arst_drop", 64'(drop_cnt), 64'd0);
    step();
    rst_n = 1;
    step();
    sweep_check();
    chk("end_sb", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
